// File: rtl/axi_mem_bridge.sv
// AXI4 slave to single-port memory bridge: one transaction at a time, AW +1 -> mem_req, AR +3 -> r_valid.
// Backpressure: W stalls on mem_gnt_i, R/B outputs hold until ready, at most one memory read outstanding.
module axi_mem_bridge #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // AW
  input  logic [AXI4_ID_WIDTH-1:0]        aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                      aw_len_i,
  input  logic [1:0]                      aw_burst_i,
  input  logic                            aw_valid_i,
  output logic                            aw_ready_o,
  // W
  input  logic [AXI4_DATA_WIDTH-1:0]      w_data_i,
  input  logic [AXI4_DATA_WIDTH/8-1:0]    w_strb_i,
  input  logic                            w_last_i,
  input  logic                            w_valid_i,
  output logic                            w_ready_o,
  // B
  output logic [AXI4_ID_WIDTH-1:0]        b_id_o,
  output logic [1:0]                      b_resp_o,
  output logic                            b_valid_o,
  input  logic                            b_ready_i,
  // AR
  input  logic [AXI4_ID_WIDTH-1:0]        ar_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                      ar_len_i,
  input  logic [1:0]                      ar_burst_i,
  input  logic                            ar_valid_i,
  output logic                            ar_ready_o,
  // R
  output logic [AXI4_ID_WIDTH-1:0]        r_id_o,
  output logic [AXI4_DATA_WIDTH-1:0]      r_data_o,
  output logic [1:0]                      r_resp_o,
  output logic                            r_last_o,
  output logic                            r_valid_o,
  input  logic                            r_ready_i,
  // memory master
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   mem_addr_o,
  output logic                            mem_we_o,
  output logic [AXI4_DATA_WIDTH/8-1:0]    mem_be_o,
  output logic [AXI4_DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic                            mem_rvalid_i,
  input  logic [AXI4_DATA_WIDTH-1:0]      mem_rdata_i
);

  localparam int ADDR_W = AXI4_ADDRESS_WIDTH;
  localparam int DATA_W = AXI4_DATA_WIDTH;
  localparam int ID_W   = AXI4_ID_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_RESP,
    READ_REQ,
    READ_WAIT,
    READ_DATA
  } state_e;

  state_e              state_q, state_d;
  logic                rr_read_q, rr_read_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                grant_r;
  logic                grant_w;
  logic                last_beat;
  logic [ADDR_W-1:0]   addr_next;

  // FIXED bursts replay the same address; INCR and WRAP/reserved step linearly.
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + ADDR_INC;
  assign last_beat = (cnt_q == 8'd0);

  assign b_id_o     = id_q;
  assign r_id_o     = id_q;
  assign r_data_o   = rdata_q;
  assign mem_addr_o = addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_read_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_read_q <= rr_read_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_read_d   = rr_read_q;
    id_d        = id_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    grant_r     = 1'b0;
    grant_w     = 1'b0;
    aw_ready_o  = 1'b0;
    ar_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    b_resp_o    = RESP_OKAY;
    r_valid_o   = 1'b0;
    r_last_o    = 1'b0;
    r_resp_o    = RESP_OKAY;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        // Read wins a tie only when the fairness flag points at it.
        grant_r    = ar_valid_i & (~aw_valid_i | rr_read_q);
        grant_w    = aw_valid_i & ~grant_r;
        ar_ready_o = grant_r;
        aw_ready_o = grant_w;
        if (grant_r) begin
          id_d      = ar_id_i;
          addr_d    = ar_addr_i;
          cnt_d     = ar_len_i;
          burst_d   = ar_burst_i;
          err_d     = 1'b0;
          rr_read_d = ~rr_read_q;
          state_d   = READ_REQ;
        end else if (grant_w) begin
          id_d      = aw_id_i;
          addr_d    = aw_addr_i;
          cnt_d     = aw_len_i;
          burst_d   = aw_burst_i;
          err_d     = 1'b0;
          rr_read_d = ~rr_read_q;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        mem_req_o   = w_valid_i;
        mem_we_o    = 1'b1;
        mem_be_o    = w_strb_i;
        mem_wdata_o = w_data_i;
        w_ready_o   = mem_gnt_i & w_valid_i;
        if (w_valid_i && mem_gnt_i) begin
          // len alone sets the beat count; a mismatched w_last only flags an error.
          if ((w_last_i != last_beat) || burst_q[1]) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WRITE_RESP;
          end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = addr_next;
          end
        end
      end

      WRITE_RESP: begin
        b_valid_o = 1'b1;
        b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (b_ready_i) begin
          state_d = IDLE;
        end
      end

      READ_REQ: begin
        mem_req_o = 1'b1;
        mem_be_o  = '1;
        if (mem_gnt_i) begin
          state_d = READ_WAIT;
        end
      end

      READ_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = READ_DATA;
        end
      end

      READ_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = last_beat;
        r_resp_o  = burst_q[1] ? RESP_SLVERR : RESP_OKAY;
        if (r_ready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_next;
            state_d = READ_REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: a one-cycle memory model plus a per-cycle serve loop that logs every handshake.
module tb_axi_mem_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
  logic [31:0] aw_addr_i, ar_addr_i, w_data_i, r_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  aw_len_i, ar_len_i;
  logic [1:0]  aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
  logic [3:0]  w_strb_i, mem_be_o;
  logic        aw_valid_i, aw_ready_o, w_last_i, w_valid_i, w_ready_o, b_valid_o, b_ready_i;
  logic        ar_valid_i, ar_ready_o, r_last_o, r_valid_o, r_ready_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
  logic        mem_stall;

  int tests = 0;
  int fails = 0;

  // Logs filled by serve()
  logic [31:0] wd[8];
  logic [3:0]  ws[8];
  logic        wl[8];
  int          wn, wi;
  logic [31:0] rd[8];
  logic        rl[8];
  logic [15:0] rid[8];
  logic [1:0]  rresp[8];
  int          rn;
  logic [15:0] bid;
  logic [1:0]  bresp;
  int          bn;
  logic [31:0] ma[16], mwd[16];
  logic        mwe[16];
  logic [3:0]  mbe[16];
  int          mn;
  logic        acc_rd[8];
  int          accn;
  int          t_acc, t_req, t_b, t_r;
  int          stall_left, rlow_left;
  logic [31:0] held_d;
  logic        held_last;
  logic        held_vld;

  always #5 clk_i = ~clk_i;

  assign mem_gnt_i = mem_req_o & ~mem_stall;

  // Memory answers each granted read one cycle later with addr ^ 0x5A5A0000.
  always @(posedge clk_i) begin
    mem_rvalid_i <= mem_req_o & mem_gnt_i & ~mem_we_o;
    mem_rdata_i  <= mem_addr_o ^ 32'h5A5A_0000;
  end

  axi_mem_bridge #(
    .AXI4_ADDRESS_WIDTH(32),
    .AXI4_DATA_WIDTH   (32),
    .AXI4_ID_WIDTH     (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .aw_id_i     (aw_id_i),
    .aw_addr_i   (aw_addr_i),
    .aw_len_i    (aw_len_i),
    .aw_burst_i  (aw_burst_i),
    .aw_valid_i  (aw_valid_i),
    .aw_ready_o  (aw_ready_o),
    .w_data_i    (w_data_i),
    .w_strb_i    (w_strb_i),
    .w_last_i    (w_last_i),
    .w_valid_i   (w_valid_i),
    .w_ready_o   (w_ready_o),
    .b_id_o      (b_id_o),
    .b_resp_o    (b_resp_o),
    .b_valid_o   (b_valid_o),
    .b_ready_i   (b_ready_i),
    .ar_id_i     (ar_id_i),
    .ar_addr_i   (ar_addr_i),
    .ar_len_i    (ar_len_i),
    .ar_burst_i  (ar_burst_i),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .r_id_o      (r_id_o),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .r_last_o    (r_last_o),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wn = 0; wi = 0; rn = 0; bn = 0; mn = 0; accn = 0;
    t_acc = -1; t_req = -1; t_b = -1; t_r = -1;
    stall_left = 0; rlow_left = 0; held_vld = 1'b0;
  endtask

  task automatic set_aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_burst_i = burst; aw_valid_i = 1'b1;
  endtask

  task automatic set_ar(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_burst_i = burst; ar_valid_i = 1'b1;
  endtask

  task automatic add_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    wd[wn] = d; ws[wn] = s; wl[wn] = l; wn++;
  endtask

  // Runs budget cycles; cycle 0 is the first cycle the prepared requests are visible.
  task automatic serve(input int budget);
    logic hs_aw, hs_ar, hs_w;
    for (int c = 0; c < budget; c++) begin
      w_valid_i = (wi < wn);
      if (wi < wn) begin
        w_data_i = wd[wi]; w_strb_i = ws[wi]; w_last_i = wl[wi];
      end
      r_ready_i = 1'b1;
      if (rlow_left > 0 && r_valid_o) begin
        r_ready_i = 1'b0;
        rlow_left--;
      end
      #1;
      mem_stall = (stall_left > 0) && mem_req_o;
      if (mem_stall) stall_left--;
      #1;
      hs_aw = aw_valid_i & aw_ready_o;
      hs_ar = ar_valid_i & ar_ready_o;
      hs_w  = w_valid_i & w_ready_o;
      if ((hs_aw || hs_ar) && accn < 8) begin
        acc_rd[accn] = hs_ar;
        accn++;
        if (t_acc < 0) t_acc = c;
      end
      if (mem_req_o && t_req < 0) t_req = c;
      if (mem_req_o && mem_gnt_i && mn < 16) begin
        ma[mn] = mem_addr_o; mwd[mn] = mem_wdata_o; mwe[mn] = mem_we_o; mbe[mn] = mem_be_o;
        mn++;
      end
      if (b_valid_o && t_b < 0) t_b = c;
      if (b_valid_o && b_ready_i) begin
        bid = b_id_o; bresp = b_resp_o; bn++;
      end
      if (r_valid_o && t_r < 0) t_r = c;
      if (r_valid_o && r_ready_i) begin
        if (rn < 8) begin
          rd[rn] = r_data_o; rl[rn] = r_last_o; rid[rn] = r_id_o; rresp[rn] = r_resp_o;
        end
        rn++;
        held_vld = 1'b0;
      end else if (r_valid_o) begin
        if (held_vld) begin
          chk("r_stable_data", r_data_o, held_d);
          chk("r_stable_last", r_last_o, held_last);
        end else begin
          held_d = r_data_o; held_last = r_last_o; held_vld = 1'b1;
        end
      end
      @(posedge clk_i);
      #1;
      if (hs_aw) aw_valid_i = 1'b0;
      if (hs_ar) ar_valid_i = 1'b0;
      if (hs_w) wi++;
    end
    w_valid_i = 1'b0;
    mem_stall = 1'b0;
  endtask

  initial begin
    aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_burst_i = '0; aw_valid_i = 1'b0;
    ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_burst_i = '0; ar_valid_i = 1'b0;
    w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_valid_i = 1'b0;
    b_ready_i = 1'b1; r_ready_i = 1'b1; mem_stall = 1'b0;
    clear_logs();

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_aw_ready", aw_ready_o, 1'b0);
    chk("rst_ar_ready", ar_ready_o, 1'b0);
    chk("rst_b_valid", b_valid_o, 1'b0);
    chk("rst_r_valid", r_valid_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Simultaneous AW and AR twice: read, write, read, write
    for (int p = 0; p < 2; p++) begin
      clear_logs();
      set_aw(16'd1 + 16'(2 * p), 32'h40, 8'd0, 2'b01);
      add_w(32'h1111_1111, 4'hF, 1'b1);
      set_ar(16'd2 + 16'(2 * p), 32'h80, 8'd0, 2'b01);
      #1;
      chk("pair_ar_ready", ar_ready_o, 1'b1);
      chk("pair_aw_ready", aw_ready_o, 1'b0);
      serve(20);
      chk("pair_accn", accn, 2);
      chk("pair_first_is_rd", acc_rd[0], 1'b1);
      chk("pair_second_is_rd", acc_rd[1], 1'b0);
      chk("pair_mn", mn, 2);
      chk("pair_m0_addr", ma[0], 32'h80);
      chk("pair_m1_addr", ma[1], 32'h40);
      chk("pair_m1_we", mwe[1], 1'b1);
      chk("pair_rid", rid[0], 16'd2 + 16'(2 * p));
      chk("pair_bid", bid, 16'd1 + 16'(2 * p));
    end

    // Single write with latency
    clear_logs();
    set_aw(16'd5, 32'h100, 8'd0, 2'b01);
    add_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    serve(10);
    chk("wr_t_acc", t_acc, 0);
    chk("wr_t_req", t_req, 1);
    chk("wr_t_b", t_b, 2);
    chk("wr_mn", mn, 1);
    chk("wr_addr", ma[0], 32'h100);
    chk("wr_data", mwd[0], 32'hDEAD_BEEF);
    chk("wr_we", mwe[0], 1'b1);
    chk("wr_be", mbe[0], 4'hF);
    chk("wr_bn", bn, 1);
    chk("wr_bid", bid, 16'd5);
    chk("wr_bresp", bresp, 2'b00);

    // Single read with latency
    clear_logs();
    set_ar(16'd7, 32'h300, 8'd0, 2'b01);
    serve(10);
    chk("rd_t_req", t_req, 1);
    chk("rd_t_r", t_r, 3);
    chk("rd_rn", rn, 1);
    chk("rd_data", rd[0], 32'h5A5A_0300);
    chk("rd_last", rl[0], 1'b1);
    chk("rd_id", rid[0], 16'd7);
    chk("rd_be", mbe[0], 4'hF);

    // INCR read burst of four
    clear_logs();
    set_ar(16'd9, 32'h200, 8'd3, 2'b01);
    serve(30);
    chk("burst_mn", mn, 4);
    chk("burst_rn", rn, 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_addr", ma[i], 32'h200 + 32'(4 * i));
      chk("burst_data", rd[i], 32'h5A5A_0200 + 32'(4 * i));
      chk("burst_last", rl[i], (i == 3));
      chk("burst_resp", rresp[i], 2'b00);
    end

    // FIXED write, len=2, w_last early on the second beat
    clear_logs();
    set_aw(16'hA, 32'h104, 8'd2, 2'b00);
    add_w(32'hA0, 4'hF, 1'b0);
    add_w(32'hA1, 4'h3, 1'b1);
    add_w(32'hA2, 4'hC, 1'b0);
    serve(20);
    chk("fix_mn", mn, 3);
    for (int i = 0; i < 3; i++) begin
      chk("fix_addr", ma[i], 32'h104);
      chk("fix_data", mwd[i], 32'hA0 + 32'(i));
    end
    chk("fix_be1", mbe[1], 4'h3);
    chk("fix_bn", bn, 1);
    chk("fix_bid", bid, 16'hA);
    chk("fix_bresp", bresp, 2'b10);

    // INCR write, len=1, correct last
    clear_logs();
    set_aw(16'hB, 32'h10, 8'd1, 2'b01);
    add_w(32'hB0, 4'hF, 1'b0);
    add_w(32'hB1, 4'hF, 1'b1);
    serve(20);
    chk("incw_mn", mn, 2);
    chk("incw_a0", ma[0], 32'h10);
    chk("incw_a1", ma[1], 32'h14);
    chk("incw_bresp", bresp, 2'b00);

    // Backpressure: grant stalled 3 cycles, r_ready low 5 cycles
    clear_logs();
    stall_left = 3;
    rlow_left  = 5;
    set_ar(16'hC, 32'h400, 8'd3, 2'b01);
    serve(60);
    chk("bp_stall_used", stall_left, 0);
    chk("bp_rlow_used", rlow_left, 0);
    chk("bp_mn", mn, 4);
    chk("bp_rn", rn, 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", rd[i], 32'h5A5A_0400 + 32'(4 * i));
      chk("bp_last", rl[i], (i == 3));
    end

    // Reset in the middle of a read burst
    clear_logs();
    set_ar(16'hE, 32'h500, 8'd3, 2'b01);
    serve(6);
    chk("mid_r_seen", rn, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_r_valid", r_valid_o, 1'b0);
    chk("mid_rst_mem_req", mem_req_o, 1'b0);
    chk("mid_rst_b_valid", b_valid_o, 1'b0);
    chk("mid_rst_w_ready", w_ready_o, 1'b0);
    chk("mid_rst_r_data", r_data_o, 32'h0);
    chk("mid_rst_mem_addr", mem_addr_o, 32'h0);
    chk("mid_rst_r_id", r_id_o, 16'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_r_valid", r_valid_o, 1'b0);

    // After reset the fairness flag favours read again
    clear_logs();
    set_aw(16'h3, 32'h700, 8'd0, 2'b01);
    add_w(32'h7777_0000, 4'hF, 1'b1);
    set_ar(16'h6, 32'h600, 8'd0, 2'b01);
    serve(20);
    chk("post_accn", accn, 2);
    chk("post_first_is_rd", acc_rd[0], 1'b1);
    chk("post_rn", rn, 1);
    chk("post_rd_data", rd[0], 32'h5A5A_0600);
    chk("post_rd_last", rl[0], 1'b1);
    chk("post_rd_id", rid[0], 16'h6);
    chk("post_bn", bn, 1);
    chk("post_bid", bid, 16'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
